// File: rtl/branch_pkg.sv
// branch_pkg: branch type encoding and 2-bit saturating counter helpers
package branch_pkg;
  typedef enum logic [2:0] {
    BR_NONE = 3'd0,
    BEQ     = 3'd1,
    BNE     = 3'd2,
    BLEZ    = 3'd3,
    BGTZ    = 3'd4,
    BLTZ    = 3'd5,
    BGEZ    = 3'd6,
    BR_RSVD = 3'd7
  } br_type_t;
  localparam logic [1:0] CTR_RESET = 2'b01;
  function automatic logic [1:0] sat_inc(input logic [1:0] c);
    return (c == 2'b11) ? c : c + 2'b01;
  endfunction
  function automatic logic [1:0] sat_dec(input logic [1:0] c);
    return (c == 2'b00) ? c : c - 2'b01;
  endfunction
endpackage

// File: rtl/bht_counter_table.sv
// bht_counter_table: DEPTH x 2-bit saturating counters, async lookup read, sync update write
module bht_counter_table
  import branch_pkg::*;
#(
  parameter int DEPTH = 64,
  parameter int IDX_W = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [IDX_W-1:0] rd_idx,
  output logic [1:0]       rd_ctr,
  input  logic             wr_en,
  input  logic [IDX_W-1:0] wr_idx,
  input  logic             wr_taken
);
  logic [1:0] ctr_q [DEPTH];
  logic [1:0] ctr_d [DEPTH];
  assign rd_ctr = ctr_q[rd_idx];
  always_comb begin
    ctr_d = ctr_q;
    if (wr_en) ctr_d[wr_idx] = wr_taken ? sat_inc(ctr_q[wr_idx]) : sat_dec(ctr_q[wr_idx]);
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) ctr_q <= '{default: CTR_RESET};
    else ctr_q <= ctr_d;
  end
endmodule

// File: rtl/branch_resolve_unit.sv
// branch_resolve_unit: resolves MIPS conditional branches one cycle after issue and trains a BHT.
// Optional resolved/mispredict counters are built when BRANCH_STATS_EN is defined.
module branch_resolve_unit
  import branch_pkg::*;
#(
  parameter int DATA_W    = 32,
  parameter int PC_W      = 32,
  parameter int BHT_DEPTH = 64
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              br_valid,
  input  logic [2:0]        br_type,
  input  logic [DATA_W-1:0] br_rs,
  input  logic [DATA_W-1:0] br_rt,
  input  logic [PC_W-1:0]   br_pc,
  input  logic              br_pred_taken,
  input  logic              flush,
  input  logic [PC_W-1:0]   lk_pc,
  output logic              lk_taken,
  output logic              res_valid,
  output logic              res_taken,
  output logic              res_mispredict,
  output logic [31:0]       stat_branches,
  output logic [31:0]       stat_mispred
);
  localparam int IDX_W = $clog2(BHT_DEPTH);
  logic       rs_neg, rs_zero, taken, known, issue;
  logic       res_valid_d, res_taken_d, res_mispredict_d;
  logic       res_valid_q, res_taken_q, res_mispredict_q;
  logic [1:0] lk_ctr;
  logic       unused;
  br_type_t   kind;
  always_comb begin
    kind    = br_type_t'(br_type);
    rs_neg  = br_rs[DATA_W-1];
    rs_zero = (br_rs == '0);
    taken   = (kind == BEQ)  ? (br_rs == br_rt) :
              (kind == BNE)  ? (br_rs != br_rt) :
              (kind == BLEZ) ? (rs_neg | rs_zero) :
              (kind == BGTZ) ? (!rs_neg && !rs_zero) :
              (kind == BLTZ) ? rs_neg :
              (kind == BGEZ) ? !rs_neg : 1'b0;
    known   = (kind != BR_NONE) && (kind != BR_RSVD);
    issue   = br_valid && known && !flush;
    res_valid_d      = issue;
    res_taken_d      = issue && taken;
    res_mispredict_d = issue && (taken != br_pred_taken);
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      res_valid_q      <= 1'b0;
      res_taken_q      <= 1'b0;
      res_mispredict_q <= 1'b0;
    end else begin
      res_valid_q      <= res_valid_d;
      res_taken_q      <= res_taken_d;
      res_mispredict_q <= res_mispredict_d;
    end
  end
  assign res_valid      = res_valid_q;
  assign res_taken      = res_taken_q;
  assign res_mispredict = res_mispredict_q;
  bht_counter_table #(.DEPTH(BHT_DEPTH), .IDX_W(IDX_W)) u_bht (
    .clk      (clk),
    .rst_n    (rst_n),
    .rd_idx   (lk_pc[IDX_W+1:2]),
    .rd_ctr   (lk_ctr),
    .wr_en    (issue),
    .wr_idx   (br_pc[IDX_W+1:2]),
    .wr_taken (taken)
  );
  assign lk_taken = lk_ctr[1];
  // PC bits outside the index field and the counter LSB are intentionally not consumed
  assign unused = ^{br_pc, lk_pc, lk_ctr[0]};
`ifdef BRANCH_STATS_EN
  logic [31:0] stat_branches_d, stat_branches_q, stat_mispred_d, stat_mispred_q;
  always_comb begin
    stat_branches_d = (issue && stat_branches_q != '1) ? stat_branches_q + 32'd1 : stat_branches_q;
    stat_mispred_d  = (res_mispredict_d && stat_mispred_q != '1) ? stat_mispred_q + 32'd1 : stat_mispred_q;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stat_branches_q <= '0;
      stat_mispred_q  <= '0;
    end else begin
      stat_branches_q <= stat_branches_d;
      stat_mispred_q  <= stat_mispred_d;
    end
  end
  assign stat_branches = stat_branches_q;
  assign stat_mispred  = stat_mispred_q;
`else
  assign stat_branches = '0;
  assign stat_mispred  = '0;
`endif
endmodule
